// File: rtl/time_set_controller.sv
// Set-mode sequencer: edits hour/minute/day in a shadow copy of the live time, then loads it with a one-cycle strobe.
// Optional auto-repeat of held Inc/Dec is enabled by defining TIMESET_AUTOREPEAT_EN.
module time_set_controller #(
   parameter int TIMEOUT    = 1024,
   parameter int REPEAT_DLY = 256,
   parameter int REPEAT_PER = 64
) (
   input  logic        i_Clk,
   input  logic        i_Clr,
   input  logic        i_Mode,
   input  logic        i_Inc,
   input  logic        i_Dec,
   input  logic [14:0] i_CTO,
   output logic [14:0] o_CTI,
   output logic        o_LD_CT,
   output logic        o_EN_CT,
   output logic [1:0]  o_Sel
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_SET_HOUR,
      ST_SET_MIN,
      ST_SET_DAY,
      ST_COMMIT
   } t_state;

   t_state            r_state;
   t_state            w_state_nxt;
   logic [14:0]       r_edit;
   logic [14:0]       w_edit_nxt;
   logic [14:0]       r_cti;
   logic [14:0]       w_cti_nxt;
   logic [TO_W-1:0]   r_to;
   logic [TO_W-1:0]   w_to_nxt;
   logic              r_mode_q;
   logic              r_inc_q;
   logic              r_dec_q;
   logic              w_mode_p;
   logic              w_inc_p;
   logic              w_dec_p;
   logic              w_rpt_inc;
   logic              w_rpt_dec;
   logic              w_up;
   logic              w_dn;
   logic              w_step;
   logic              w_activity;

   // Out-of-range captured values wrap the same way as the top of range.
   function automatic logic [4:0] f_hour(input logic [4:0] h, input logic up);
      logic [4:0] r;
      if (up) r = (h >= 5'd23) ? 5'd0 : h + 5'd1;
      else    r = (h == 5'd0) ? 5'd23 : h - 5'd1;
      return r;
   endfunction

   function automatic logic [6:0] f_min(input logic [6:0] m, input logic up);
      logic [2:0] t;
      logic [3:0] u;
      t = m[6:4];
      u = m[3:0];
      if (up) begin
         if (u >= 4'd9) begin
            u = 4'd0;
            t = (t >= 3'd5) ? 3'd0 : t + 3'd1;
         end else begin
            u = u + 4'd1;
         end
      end else begin
         if (u == 4'd0) begin
            u = 4'd9;
            t = (t == 3'd0) ? 3'd5 : t - 3'd1;
         end else begin
            u = u - 4'd1;
         end
      end
      return {t, u};
   endfunction

   function automatic logic [2:0] f_day(input logic [2:0] d, input logic up);
      logic [2:0] r;
      if (up) r = (d >= 3'd6) ? 3'd0 : d + 3'd1;
      else    r = (d == 3'd0) ? 3'd6 : d - 3'd1;
      return r;
   endfunction

   assign w_mode_p = i_Mode & ~r_mode_q;
   assign w_inc_p  = i_Inc & ~r_inc_q;
   assign w_dec_p  = i_Dec & ~r_dec_q;

`ifdef TIMESET_AUTOREPEAT_EN
   localparam int RPT_W = $clog2(((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER) + 1);

   logic [RPT_W-1:0] r_rpt_cnt;
   logic             r_rpt_run;
   logic [RPT_W-1:0] w_rpt_lim;
   logic             w_hold_inc;
   logic             w_hold_dec;
   logic             w_rpt_hit;

   // Holding both buttons counts as neither being held.
   assign w_hold_inc = i_Inc & r_inc_q & ~i_Dec;
   assign w_hold_dec = i_Dec & r_dec_q & ~i_Inc;
   assign w_rpt_lim  = r_rpt_run ? RPT_W'(REPEAT_PER) : RPT_W'(REPEAT_DLY);
   assign w_rpt_hit  = (w_hold_inc | w_hold_dec) && (r_rpt_cnt == w_rpt_lim);
   assign w_rpt_inc  = w_rpt_hit & w_hold_inc;
   assign w_rpt_dec  = w_rpt_hit & w_hold_dec;

   always_ff @(posedge i_Clk or posedge i_Clr) begin
      if (i_Clr) begin
         r_rpt_cnt <= '0;
         r_rpt_run <= 1'b0;
      end else if (w_inc_p | w_dec_p) begin
         r_rpt_cnt <= RPT_W'(1);
         r_rpt_run <= 1'b0;
      end else if (w_hold_inc | w_hold_dec) begin
         if (w_rpt_hit) begin
            r_rpt_cnt <= RPT_W'(1);
            r_rpt_run <= 1'b1;
         end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
         end
      end else begin
         r_rpt_cnt <= '0;
         r_rpt_run <= 1'b0;
      end
   end
`else
   assign w_rpt_inc = 1'b0;
   assign w_rpt_dec = 1'b0;
`endif

   assign w_up       = w_inc_p | w_rpt_inc;
   assign w_dn       = w_dec_p | w_rpt_dec;
   assign w_step     = w_up ^ w_dn;
   assign w_activity = w_mode_p | w_inc_p | w_dec_p | w_rpt_inc | w_rpt_dec;

   always_ff @(posedge i_Clk or posedge i_Clr) begin
      if (i_Clr) begin
         r_state  <= ST_RUN;
         r_edit   <= '0;
         r_cti    <= '0;
         r_to     <= '0;
         r_mode_q <= 1'b0;
         r_inc_q  <= 1'b0;
         r_dec_q  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_edit   <= w_edit_nxt;
         r_cti    <= w_cti_nxt;
         r_to     <= w_to_nxt;
         r_mode_q <= i_Mode;
         r_inc_q  <= i_Inc;
         r_dec_q  <= i_Dec;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_edit_nxt  = r_edit;
      w_cti_nxt   = r_cti;
      w_to_nxt    = r_to;
      case (r_state)
         ST_RUN: begin
            w_to_nxt = '0;
            if (w_mode_p) begin
               w_state_nxt = ST_SET_HOUR;
               w_edit_nxt  = i_CTO;
            end
         end
         ST_SET_HOUR, ST_SET_MIN, ST_SET_DAY: begin
            if (w_activity) w_to_nxt = '0;
            else            w_to_nxt = r_to + 1'b1;
            // Mode outranks both a pending step and timeout expiry.
            if (w_mode_p) begin
               case (r_state)
                  ST_SET_HOUR: w_state_nxt = ST_SET_MIN;
                  ST_SET_MIN:  w_state_nxt = ST_SET_DAY;
                  default: begin
                     w_state_nxt = ST_COMMIT;
                     w_cti_nxt   = r_edit;
                  end
               endcase
            end else if (!w_activity && (r_to == TO_W'(TIMEOUT - 1))) begin
               w_state_nxt = ST_RUN;
               w_to_nxt    = '0;
            end else if (w_step) begin
               case (r_state)
                  ST_SET_HOUR: w_edit_nxt[11:7]  = f_hour(r_edit[11:7], w_up);
                  ST_SET_MIN:  w_edit_nxt[6:0]   = f_min(r_edit[6:0], w_up);
                  default:     w_edit_nxt[14:12] = f_day(r_edit[14:12], w_up);
               endcase
            end
         end
         ST_COMMIT: begin
            w_state_nxt = ST_RUN;
            w_to_nxt    = '0;
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_to_nxt    = '0;
         end
      endcase
   end

   always_comb begin
      o_Sel   = 2'd0;
      o_EN_CT = 1'b0;
      o_LD_CT = 1'b0;
      case (r_state)
         ST_RUN:      o_EN_CT = 1'b1;
         ST_SET_HOUR: o_Sel   = 2'd1;
         ST_SET_MIN:  o_Sel   = 2'd2;
         ST_SET_DAY:  o_Sel   = 2'd3;
         ST_COMMIT:   o_LD_CT = 1'b1;
         default:     o_EN_CT = 1'b1;
      endcase
   end

   assign o_CTI = r_cti;

endmodule
